// File: rtl/tnn_feature_tx.sv
// tnn_feature_tx: quantizing front-end for the 3x3-bit TNN classifier cores.
// It collects three raw samples per frame (a, b, c), turns each into a 3-bit
// code by counting how many per-feature thresholds the sample reaches, and
// hands the packed vector to the classifier over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_valid/s_ready     raw sample handshake (s_ready registered from state)
//   s_data, s_last      raw unsigned sample, marks the c sample of a frame
//   m_valid/m_ready     quantized vector handshake
//   m_a, m_b, m_c       quantized codes (drive classifier input_a/b/c)
//   thr_we, thr_sel,    threshold write port: feature 0..2, level 1..7
//   thr_idx, thr_data
//   vec_cnt             number of vectors handed off (wrapping)
//   err_frame           one-cycle pulse on a framing error
module tnn_feature_tx #(
    parameter int unsigned RAW_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [RAW_W-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [2:0]       m_a,
    output logic [2:0]       m_b,
    output logic [2:0]       m_c,
    input  logic             thr_we,
    input  logic [1:0]       thr_sel,
    input  logic [2:0]       thr_idx,
    input  logic [RAW_W-1:0] thr_data,
    output logic [CNT_W-1:0] vec_cnt,
    output logic             err_frame
);

    typedef enum logic [1:0] {
        COL_A = 2'd0,
        COL_B = 2'd1,
        COL_C = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state;

    // Threshold table; only rows 0..2 and levels 1..7 are ever written or read.
    logic [RAW_W-1:0] thr [4][8];

    logic [2:0] a_q;
    logic [2:0] b_q;
    logic [1:0] fsel_c;
    logic [2:0] code_c;
    logic       accept_c;

    assign accept_c = s_valid & s_ready;

    // Quantize the incoming sample against the thresholds of the feature
    // selected by the current collection state.
    always_comb begin
        fsel_c = 2'd0;
        code_c = 3'd0;
        case (state)
            COL_B:   fsel_c = 2'd1;
            COL_C:   fsel_c = 2'd2;
            default: fsel_c = 2'd0;
        endcase
        for (int k = 1; k < 8; k++) begin
            if (s_data >= thr[fsel_c][k]) begin
                code_c = code_c + 3'd1;
            end
        end
    end

    // Threshold storage; an accept in the same cycle sees the pre-write value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int f = 0; f < 4; f++) begin
                for (int k = 0; k < 8; k++) begin
                    thr[f][k] <= RAW_W'(k) << (RAW_W - 3);
                end
            end
        end else if (thr_we && (thr_sel != 2'd3) && (thr_idx != 3'd0)) begin
            thr[thr_sel][thr_idx] <= thr_data;
        end
    end

    // Frame collection FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COL_A;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            m_a       <= 3'd0;
            m_b       <= 3'd0;
            m_c       <= 3'd0;
            a_q       <= 3'd0;
            b_q       <= 3'd0;
            vec_cnt   <= '0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            case (state)
                COL_A: begin
                    if (accept_c) begin
                        if (s_last) begin
                            err_frame <= 1'b1;
                        end else begin
                            a_q   <= code_c;
                            state <= COL_B;
                        end
                    end
                end
                COL_B: begin
                    if (accept_c) begin
                        if (s_last) begin
                            err_frame <= 1'b1;
                            state     <= COL_A;
                        end else begin
                            b_q   <= code_c;
                            state <= COL_C;
                        end
                    end
                end
                COL_C: begin
                    if (accept_c) begin
                        if (s_last) begin
                            // Outputs only change when a full frame lands, so
                            // they keep the last vector while the next collects.
                            m_a     <= a_q;
                            m_b     <= b_q;
                            m_c     <= code_c;
                            m_valid <= 1'b1;
                            s_ready <= 1'b0;
                            state   <= HOLD;
                        end else begin
                            err_frame <= 1'b1;
                            state     <= COL_A;
                        end
                    end
                end
                HOLD: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        vec_cnt <= vec_cnt + CNT_W'(1);
                        state   <= COL_A;
                    end
                end
                default: begin
                    state   <= COL_A;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tnn_feature_tx.sv
// Directed bench for tnn_feature_tx. A second instance with CNT_W=4 shares
// all inputs so counter wrap can be reached in a short run.
module tb_tnn_feature_tx;

    localparam int unsigned RAW_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic [RAW_W-1:0] s_data;
    logic             s_last;
    logic             m_ready;
    logic             thr_we;
    logic [1:0]       thr_sel;
    logic [2:0]       thr_idx;
    logic [RAW_W-1:0] thr_data;

    logic        s_ready, m_valid, err_frame;
    logic [2:0]  m_a, m_b, m_c;
    logic [15:0] vec_cnt;

    logic        s_ready4, m_valid4, err_frame4;
    logic [2:0]  m_a4, m_b4, m_c4;
    logic [3:0]  vec_cnt4;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    tnn_feature_tx #(.RAW_W(RAW_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_a(m_a), .m_b(m_b), .m_c(m_c),
        .thr_we(thr_we), .thr_sel(thr_sel), .thr_idx(thr_idx), .thr_data(thr_data),
        .vec_cnt(vec_cnt), .err_frame(err_frame)
    );

    tnn_feature_tx #(.RAW_W(RAW_W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid4), .m_ready(m_ready),
        .m_a(m_a4), .m_b(m_b4), .m_c(m_c4),
        .thr_we(thr_we), .thr_sel(thr_sel), .thr_idx(thr_idx), .thr_data(thr_data),
        .vec_cnt(vec_cnt4), .err_frame(err_frame4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One raw sample; waits (bounded) for s_ready before presenting it.
    task automatic send(input logic [RAW_W-1:0] d, input logic last);
        int n = 0;
        while (s_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("send_ready_timeout", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic frame(input logic [RAW_W-1:0] a, input logic [RAW_W-1:0] b,
                         input logic [RAW_W-1:0] c);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b1);
    endtask

    task automatic handoff();
        chk("handoff_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        exp_cnt++;
        chk("handoff_valid_drop", 32'(m_valid), 32'd0);
        chk("handoff_vec_cnt", 32'(vec_cnt), 32'(exp_cnt & 16'hFFFF));
    endtask

    task automatic thr_write(input logic [1:0] sel, input logic [2:0] idx,
                             input logic [RAW_W-1:0] val);
        thr_we   = 1'b1;
        thr_sel  = sel;
        thr_idx  = idx;
        thr_data = val;
        tick();
        thr_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        thr_we = 1'b0; thr_sel = 2'd0; thr_idx = 3'd0; thr_data = '0;
        tick();
        tick();
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_abc", 32'({m_a, m_b, m_c}), 32'd0);
        chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
        chk("rst_err", 32'(err_frame), 32'd0);
        rst_n = 1'b1;

        // Default thresholds 32..224: 0->0, 100->3, 255->7.
        send(8'd0, 1'b0);
        send(8'd100, 1'b0);
        chk("f1_valid_before_c", 32'(m_valid), 32'd0);
        send(8'd255, 1'b1);
        chk("f1_valid_after_c", 32'(m_valid), 32'd1);
        chk("f1_s_ready_hold", 32'(s_ready), 32'd0);
        chk("f1_m_a", 32'(m_a), 32'd0);
        chk("f1_m_b", 32'(m_b), 32'd3);
        chk("f1_m_c", 32'(m_c), 32'd7);
        handoff();
        chk("f1_s_ready_after", 32'(s_ready), 32'd1);
        chk("f1_m_b_retained", 32'(m_b), 32'd3);

        // Backpressure: 31->0, 32->1, 224->7 held for 10 cycles.
        frame(8'd31, 8'd32, 8'd224);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(m_valid), 32'd1);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            chk("bp_abc", 32'({m_a, m_b, m_c}), 32'({3'd0, 3'd1, 3'd7}));
            chk("bp_vec_cnt", 32'(vec_cnt), 32'd1);
        end
        handoff();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("bp_no_extra_handoff", 32'(vec_cnt), 32'd2);

        // Feature b thresholds 10,20,...,70: 45 -> 4.
        for (int k = 1; k < 8; k++) thr_write(2'd1, 3'(k), 8'(10 * k));
        frame(8'd0, 8'd45, 8'd0);
        chk("thr_m_b_45", 32'(m_b), 32'd4);
        chk("thr_m_a_default", 32'(m_a), 32'd0);
        handoff();

        // Write T[1][4]=45 concurrently with a b accept of 45.
        send(8'd0, 1'b0);
        thr_we = 1'b1; thr_sel = 2'd1; thr_idx = 3'd4; thr_data = 8'd45;
        send(8'd45, 1'b0);
        thr_we = 1'b0;
        send(8'd0, 1'b1);
        chk("thr_same_cycle_4", 32'(m_b), 32'd4);
        handoff();
        frame(8'd0, 8'd45, 8'd0);
        chk("thr_after_write_4", 32'(m_b), 32'd4);
        handoff();

        // Write T[1][5]=44 (was 50) with the accept: old gives 4, new gives 5.
        send(8'd0, 1'b0);
        thr_we = 1'b1; thr_sel = 2'd1; thr_idx = 3'd5; thr_data = 8'd44;
        send(8'd45, 1'b0);
        thr_we = 1'b0;
        send(8'd0, 1'b1);
        chk("thr_old_value_used", 32'(m_b), 32'd4);
        handoff();
        frame(8'd0, 8'd45, 8'd0);
        chk("thr_new_value_used", 32'(m_b), 32'd5);
        handoff();

        // Ignored writes: sel=3 and idx=0 must not disturb feature a/c.
        thr_write(2'd3, 3'd1, 8'd0);
        thr_write(2'd0, 3'd0, 8'd0);
        frame(8'd31, 8'd0, 8'd31);
        chk("ignored_write_a", 32'(m_a), 32'd0);
        chk("ignored_write_c", 32'(m_c), 32'd0);
        handoff();

        // s_last on a: error, sample dropped, stay in COL_A.
        send(8'd7, 1'b1);
        chk("err_on_a", 32'(err_frame), 32'd1);
        chk("err_on_a_ready", 32'(s_ready), 32'd1);
        // s_last on b: error, partial frame dropped.
        send(8'd0, 1'b0);
        chk("err_pulse_clear", 32'(err_frame), 32'd0);
        send(8'd100, 1'b1);
        chk("err_on_b", 32'(err_frame), 32'd1);
        chk("err_on_b_no_valid", 32'(m_valid), 32'd0);
        // Next correct frame: b=50 with 10,20,30,45,44,60,70 -> 5.
        frame(8'd255, 8'd50, 8'd64);
        chk("post_err_valid", 32'(m_valid), 32'd1);
        chk("post_err_abc", 32'({m_a, m_b, m_c}), 32'({3'd7, 3'd5, 3'd2}));
        chk("post_err_pulse_gone", 32'(err_frame), 32'd0);
        handoff();
        // Third sample without s_last.
        send(8'd0, 1'b0);
        send(8'd0, 1'b0);
        send(8'd0, 1'b0);
        chk("err_on_c", 32'(err_frame), 32'd1);
        chk("err_on_c_no_valid", 32'(m_valid), 32'd0);
        tick();
        chk("err_on_c_pulse_once", 32'(err_frame), 32'd0);
        chk("err_on_c_cnt", 32'(vec_cnt), 32'(exp_cnt));

        // Run to 16 hand-offs: the CNT_W=4 copy wraps to 0.
        while (exp_cnt < 16) begin
            frame(8'd224, 8'd0, 8'd96);
            handoff();
        end
        chk("wrap_cnt16", 32'(vec_cnt), 32'd16);
        chk("wrap_cnt4", 32'(vec_cnt4), 32'd0);
        chk("wrap4_abc", 32'({m_a4, m_b4, m_c4}), 32'({3'd7, 3'd0, 3'd3}));
        chk("wrap4_handshake", 32'({s_ready4, m_valid4, err_frame4}), 32'({1'b1, 1'b0, 1'b0}));
        frame(8'd0, 8'd0, 8'd0);
        handoff();
        chk("wrap_cnt4_next", 32'(vec_cnt4), 32'd1);

        // Reset while in COL_C.
        send(8'd0, 1'b0);
        send(8'd100, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        chk("rstc_m_valid", 32'(m_valid), 32'd0);
        chk("rstc_s_ready", 32'(s_ready), 32'd1);
        chk("rstc_vec_cnt", 32'(vec_cnt), 32'd0);
        // Default thresholds restored: 100 -> 3 on feature b.
        frame(8'd0, 8'd100, 8'd0);
        chk("rstc_default_thr", 32'(m_b), 32'd3);
        chk("rstc_frame_valid", 32'(m_valid), 32'd1);

        // Reset while in HOLD discards the held vector.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rsth_m_valid", 32'(m_valid), 32'd0);
        chk("rsth_s_ready", 32'(s_ready), 32'd1);
        chk("rsth_m_b", 32'(m_b), 32'd0);
        frame(8'd255, 8'd0, 8'd0);
        chk("rsth_next_frame", 32'({m_a, m_b, m_c}), 32'({3'd7, 3'd0, 3'd0}));
        handoff();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
